// File: rtl/fetch_pkg.sv
// Shared types and default widths for the program-counter / fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CYC_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/cycle_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module cycle_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// PC register and start/run/halt sequencing upstream of the instruction ROM.
// Define PC_CYCLE_COUNT_EN to build the saturating RUN-cycle counter on CycleCnt.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned A  = PC_W,
    parameter int unsigned CW = CYC_W
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [A-1:0]  StartAddr,
    input  logic          Stall,
    input  logic          BranchAbs,
    input  logic          BranchRel,
    input  logic [A-1:0]  Target,
    input  logic          HaltReq,
    output logic [A-1:0]  PC,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCnt
);

    fetch_state_t state;
    logic [A-1:0] pc_q;

    // FSM and next-PC selection; a relative branch adds Target modulo 2^A,
    // which covers negative offsets without sign extension.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            pc_q  <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (Start) begin
                        state <= RUN;
                        pc_q  <= StartAddr;
                    end
                end
                RUN: begin
                    if (HaltReq) begin
                        state <= HALTED;
                    end else if (!Stall) begin
                        if (BranchAbs) begin
                            pc_q <= Target;
                        end else if (BranchRel) begin
                            pc_q <= pc_q + Target;
                        end else begin
                            pc_q <= pc_q + A'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pc_q  <= '0;
                end
            endcase
        end
    end

    assign PC      = pc_q;
    assign Running = (state == RUN);
    assign Done    = (state == HALTED);

`ifdef PC_CYCLE_COUNT_EN
    logic start_accept_c;
    assign start_accept_c = Start && (state != RUN);

    cycle_counter #(
        .W (CW)
    ) u_cycle_counter (
        .clk   (Clk),
        .rst   (Reset),
        .clr   (start_accept_c),
        .en    (state == RUN),
        .count (CycleCnt)
    );
`else
    assign CycleCnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized traffic vs. a reference model.
module tb_pc_fetch;

    localparam int unsigned A  = 10;
    localparam int unsigned CW = 4;
    localparam int          PC_MOD  = 1 << A;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset, Start, Stall, BranchAbs, BranchRel, HaltReq;
    logic [A-1:0]  StartAddr, Target;
    logic [A-1:0]  PC;
    logic          Running, Done;
    logic [CW-1:0] CycleCnt;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = idle, 1 = running, 2 = halted
    int m_state = 0;
    int m_pc    = 0;
    int m_cnt   = 0;

    always #5 Clk = ~Clk;

    pc_fetch #(.A(A), .CW(CW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .StartAddr (StartAddr),
        .Stall     (Stall),
        .BranchAbs (BranchAbs),
        .BranchRel (BranchRel),
        .Target    (Target),
        .HaltReq   (HaltReq),
        .PC        (PC),
        .Running   (Running),
        .Done      (Done),
        .CycleCnt  (CycleCnt)
    );

    function automatic int exp_cnt();
`ifdef PC_CYCLE_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
    task automatic step(input logic rst, input logic st, input int sa, input logic stl,
                        input logic ba, input logic br, input int tg, input logic hr);
        @(negedge Clk);
        Reset = rst; Start = st; StartAddr = A'(sa); Stall = stl;
        BranchAbs = ba; BranchRel = br; Target = A'(tg); HaltReq = hr;
        @(posedge Clk);
        if (rst) begin
            m_state = 0; m_pc = 0; m_cnt = 0;
        end else if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_pc = sa % PC_MOD; m_cnt = 0;
            end
        end else begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (hr)       m_state = 2;
            else if (stl) m_pc = m_pc;
            else if (ba)  m_pc = tg % PC_MOD;
            else if (br)  m_pc = (m_pc + tg) % PC_MOD;
            else          m_pc = (m_pc + 1) % PC_MOD;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 77, 0, 1, 0, 9, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        total++; if (PC !== 10'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", PC); end
        total++; if (Running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", Running); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", Done); end
        total++; if (CycleCnt !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", CycleCnt); end
        step(0, 0, 0, 1, 1, 1, 50, 1);
        total++; if (PC !== 10'd0 || Running !== 1'b0) begin bad++; $display("FAIL idle_hold: pc %0d run %b want 0 0", PC, Running); end
    endtask

    task automatic test_start_seq();
        step(0, 1, 5, 0, 0, 0, 0, 0);
        total++; if (PC !== 10'd5) begin bad++; $display("FAIL start_pc: got %0d want 5", PC); end
        total++; if (Running !== 1'b1) begin bad++; $display("FAIL start_running: got %b want 1", Running); end
        for (int i = 0; i < 3; i++) begin
            step(0, (i == 1), 0, 0, 0, 0, 0, 0);
            total++; if (PC !== 10'(6 + i)) begin bad++; $display("FAIL seq_pc: got %0d want %0d", PC, 6 + i); end
        end
    endtask

    task automatic test_branches();
        step(0, 0, 0, 0, 1, 0, 100, 0);
        total++; if (PC !== 10'd100) begin bad++; $display("FAIL br_abs: got %0d want 100", PC); end
        step(0, 0, 0, 0, 0, 1, 'h3FD, 0);
        total++; if (PC !== 10'd97) begin bad++; $display("FAIL br_rel_neg: got %0d want 97", PC); end
        step(0, 0, 0, 0, 1, 1, 20, 0);
        total++; if (PC !== 10'd20) begin bad++; $display("FAIL br_both: got %0d want 20", PC); end
    endtask

    task automatic test_wrap();
        step(0, 0, 0, 0, 1, 0, 1023, 0);
        total++; if (PC !== 10'd1023) begin bad++; $display("FAIL wrap_setup: got %0d want 1023", PC); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (PC !== 10'd0) begin bad++; $display("FAIL wrap_inc: got %0d want 0", PC); end
        step(0, 0, 0, 0, 1, 0, 2, 0);
        step(0, 0, 0, 0, 0, 1, 'h3FC, 0);
        total++; if (PC !== 10'd1022) begin bad++; $display("FAIL wrap_rel: got %0d want 1022", PC); end
    endtask

    task automatic test_stall_halt();
        step(0, 0, 0, 0, 1, 0, 40, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 1, 1, 0, 77, 0);
            total++; if (PC !== 10'd40) begin bad++; $display("FAIL stall_pc: got %0d want 40", PC); end
        end
        step(0, 0, 0, 1, 0, 0, 0, 1);
        total++; if (Done !== 1'b1 || Running !== 1'b0) begin bad++; $display("FAIL halt_flags: done %b run %b want 1 0", Done, Running); end
        total++; if (PC !== 10'd40) begin bad++; $display("FAIL halt_pc: got %0d want 40", PC); end
        step(0, 0, 0, 0, 1, 1, 9, 0);
        total++; if (PC !== 10'd40 || Done !== 1'b1) begin bad++; $display("FAIL halted_hold: pc %0d done %b want 40 1", PC, Done); end
        step(0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (PC !== 10'd0 || Done !== 1'b0 || Running !== 1'b1) begin
            bad++; $display("FAIL restart: pc %0d done %b run %b want 0 0 1", PC, Done, Running);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 0, 1, 0, 300, 0);
        total++; if (PC !== 10'd300) begin bad++; $display("FAIL mid_setup: got %0d want 300", PC); end
        step(1, 1, 12, 0, 1, 0, 55, 0);
        total++; if (PC !== 10'd0 || Running !== 1'b0 || Done !== 1'b0) begin
            bad++; $display("FAIL mid_reset: pc %0d run %b done %b want 0 0 0", PC, Running, Done);
        end
    endtask

    task automatic test_cycle_cnt();
        int want;
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, (i % 3 == 0), 0, 0, 0, 0);
`ifdef PC_CYCLE_COUNT_EN
        want = 15;
`else
        want = 0;
`endif
        total++; if (CycleCnt !== CW'(want)) begin bad++; $display("FAIL cnt_sat: got %0d want %0d", CycleCnt, want); end
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (CycleCnt !== CW'(want) || Done !== 1'b1) begin
            bad++; $display("FAIL cnt_halt_hold: got %0d done %b want %0d 1", CycleCnt, Done, want);
        end
        step(0, 1, 3, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PC_CYCLE_COUNT_EN
        want = 1;
`else
        want = 0;
`endif
        total++; if (CycleCnt !== CW'(want)) begin bad++; $display("FAIL cnt_clear: got %0d want %0d", CycleCnt, want); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0), int'($urandom_range(0, PC_MOD - 1)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, PC_MOD - 1)), ($urandom_range(0, 29) == 0));
            total++; if (PC !== A'(m_pc)) begin bad++; $display("FAIL rnd_pc[%0d]: got %0d want %0d", i, PC, m_pc); end
            total++; if (Running !== (m_state == 1)) begin bad++; $display("FAIL rnd_running[%0d]: got %b want %b", i, Running, m_state == 1); end
            total++; if (Done !== (m_state == 2)) begin bad++; $display("FAIL rnd_done[%0d]: got %b want %b", i, Done, m_state == 2); end
            total++; if (CycleCnt !== CW'(exp_cnt())) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, CycleCnt, exp_cnt()); end
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; StartAddr = '0; Stall = 1'b0;
        BranchAbs = 1'b0; BranchRel = 1'b0; Target = '0; HaltReq = 1'b0;
        test_reset();
        test_start_seq();
        test_branches();
        test_wrap();
        test_stall_halt();
        test_reset_mid();
        test_cycle_cnt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
